// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - Keccak mode encoding, rate table, domain bytes and FSM states
//
// Shared by keccak_absorb_sipo (and its optional padder).
//   mode_e     : 3-bit hash mode encoding (6 and 7 fold onto SHAKE128)
//   state_e    : absorb FSM states
//   rate_bits  : rate of a mode in bits
//   rate_words : rate of a mode in words of a given width
//   domain_byte: first padding byte (SHA3 0x06, SHAKE 0x1F)
package keccak_pkg;

    localparam int RB_W = 11;   // wide enough for any rate in bits (max 1344)

    typedef enum logic [2:0] {
        MODE_SHA3_224 = 3'd0,
        MODE_SHA3_256 = 3'd1,
        MODE_SHA3_384 = 3'd2,
        MODE_SHA3_512 = 3'd3,
        MODE_SHAKE128 = 3'd4,
        MODE_SHAKE256 = 3'd5
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2,
        FULL = 2'd3
    } state_e;

    localparam logic [7:0] DOM_SHA3  = 8'h06;
    localparam logic [7:0] DOM_SHAKE = 8'h1F;

    function automatic mode_e norm_mode(input logic [2:0] m);
        if (m > 3'd5) begin
            return MODE_SHAKE128;
        end
        return mode_e'(m);
    endfunction

    function automatic logic [RB_W-1:0] rate_bits(input mode_e m);
        case (m)
            MODE_SHA3_224: return 11'd1152;
            MODE_SHA3_256: return 11'd1088;
            MODE_SHA3_384: return 11'd832;
            MODE_SHA3_512: return 11'd576;
            MODE_SHAKE256: return 11'd1088;
            default:       return 11'd1344;
        endcase
    endfunction

    function automatic logic [RB_W-1:0] rate_words(input mode_e m, input int w);
        return RB_W'(int'(rate_bits(m)) / w);
    endfunction

    function automatic logic [7:0] domain_byte(input mode_e m);
        return (m == MODE_SHAKE128 || m == MODE_SHAKE256) ? DOM_SHAKE : DOM_SHA3;
    endfunction

endpackage

// File: rtl/keccak_pad_byte.sv
// rtl/keccak_pad_byte.sv - per-byte pad10*1 masking for the last message word
//
// Present only when KECCAK_SIPO_PAD_EN is defined.
//   byte_idx : position of this byte within the word
//   pad_idx  : number of valid message bytes in the word (in_bytes)
//   domain   : domain separation byte for the latched mode
//   mask     : 0xFF to keep the message byte, 0x00 to clear it
//   value    : domain byte when this is the first byte after the message, else 0
`ifdef KECCAK_SIPO_PAD_EN
module keccak_pad_byte #(
    parameter int IW = 4
) (
    input  logic [IW-1:0] byte_idx,
    input  logic [IW-1:0] pad_idx,
    input  logic [7:0]    domain,
    output logic [7:0]    mask,
    output logic [7:0]    value
);

    always_comb begin
        mask  = (byte_idx < pad_idx) ? 8'hFF : 8'h00;
        value = (byte_idx == pad_idx) ? domain : 8'h00;
    end

endmodule
`endif

// File: rtl/keccak_absorb_sipo.sv
// rtl/keccak_absorb_sipo.sv - serial-in parallel-out block builder for the Keccak sponge
//
// Collects W-bit words into a rate-sized block (first word least significant)
// and hands it out on a valid/ready block interface.
// Optional pad10*1 padder: define KECCAK_SIPO_PAD_EN.
//   clk, rst_n                     : clock, synchronous active-low reset
//   start, mode                    : begin message, latch hash mode
//   in_valid/in_ready/in_data      : word input handshake
//   in_last, in_bytes              : final word marker, valid bytes in it
//   blk_valid/blk_ready/blk_data   : block output handshake
//   blk_last                       : final block of the message
//   busy                           : not idle
module keccak_absorb_sipo
    import keccak_pkg::*;
#(
    parameter int W        = 64,
    parameter int RATE_MAX = 1344
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    input  logic                    in_last,
    input  logic [$clog2(W/8):0]    in_bytes,
    output logic                    blk_valid,
    input  logic                    blk_ready,
    output logic [RATE_MAX-1:0]     blk_data,
    output logic                    blk_last,
    output logic                    busy
);

    localparam int NWORDS = RATE_MAX / W;
    localparam int IB_W   = $clog2(W/8) + 1;

    state_e                state_q, state_d;
    mode_e                 mode_q, mode_d;
    logic [RB_W-1:0]       cnt_q, cnt_d;
    logic [RATE_MAX-1:0]   blk_data_q, blk_data_d;
    logic                  last_q, last_d;
    logic                  pad_pend_q, pad_pend_d;   // a pure pad block must follow

    logic [RB_W-1:0]       rw_last;
    logic [RB_W-1:0]       rate_idx;                 // final rate bit, gets the closing 1
    logic [W-1:0]          word_in;

    assign rw_last  = rate_words(mode_q, W) - 11'd1;
    assign rate_idx = rate_bits(mode_q) - 11'd1;

`ifdef KECCAK_SIPO_PAD_EN
    localparam int NB = W / 8;

    logic [7:0]   dom;
    logic [W-1:0] pad_word;
    logic         full_word;

    assign dom       = domain_byte(mode_q);
    assign full_word = (in_bytes >= IB_W'(NB));

    for (genvar j = 0; j < NB; j++) begin : g_pad
        logic [7:0] m;
        logic [7:0] v;
        keccak_pad_byte #(.IW(IB_W)) u_pad (
            .byte_idx (IB_W'(j)),
            .pad_idx  (in_bytes),
            .domain   (dom),
            .mask     (m),
            .value    (v)
        );
        assign pad_word[8*j +: 8] = (in_data[8*j +: 8] & m) | v;
    end

    assign word_in = in_last ? pad_word : in_data;
`else
    logic unused_in_bytes;
    assign unused_in_bytes = ^in_bytes;
    assign word_in         = in_data;
`endif

    assign in_ready  = (state_q == FILL);
    assign blk_valid = (state_q == FULL);
    assign busy      = (state_q != IDLE);
    assign blk_last  = last_q;
    assign blk_data  = blk_data_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        blk_data_d = blk_data_q;
        last_d     = last_q;
        pad_pend_d = pad_pend_q;

        // start wins over any handshake on the same edge; a word offered now is dropped
        if (start) begin
            state_d    = FILL;
            mode_d     = norm_mode(mode);
            cnt_d      = '0;
            blk_data_d = '0;
            last_d     = 1'b0;
            pad_pend_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_valid) begin
                        for (int i = 0; i < NWORDS; i++) begin
                            if (RB_W'(i) == cnt_q) begin
                                blk_data_d[i*W +: W] = word_in;
                            end
                        end
                        if (in_last) begin
                            state_d = FULL;
`ifdef KECCAK_SIPO_PAD_EN
                            if (full_word && cnt_q == rw_last) begin
                                // no room left for padding: emit data block, pad block follows
                                pad_pend_d = 1'b1;
                                last_d     = 1'b0;
                            end else begin
                                if (full_word) begin
                                    for (int i = 0; i < NWORDS; i++) begin
                                        if (RB_W'(i) == cnt_q + 11'd1) begin
                                            blk_data_d[i*W +: 8] = dom;
                                        end
                                    end
                                end
                                // buffer is zero above the write, so setting the bit equals OR 0x80
                                blk_data_d[rate_idx] = 1'b1;
                                last_d               = 1'b1;
                            end
`else
                            last_d = 1'b1;
`endif
                        end else if (cnt_q == rw_last) begin
                            state_d = FULL;
                        end else begin
                            cnt_d = cnt_q + 11'd1;
                        end
                    end
                end
                FULL: begin
                    if (blk_ready) begin
                        blk_data_d = '0;
                        cnt_d      = '0;
                        last_d     = 1'b0;
                        if (last_q) begin
                            state_d = IDLE;
                        end else if (pad_pend_q) begin
                            state_d = PAD;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
                PAD: begin
`ifdef KECCAK_SIPO_PAD_EN
                    blk_data_d[7:0]      = dom;
                    blk_data_d[rate_idx] = 1'b1;
                    pad_pend_d           = 1'b0;
                    last_d               = 1'b1;
                    state_d              = FULL;
`else
                    state_d = IDLE;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_SHA3_224;
            cnt_q      <= '0;
            blk_data_q <= '0;
            last_q     <= 1'b0;
            pad_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            blk_data_q <= blk_data_d;
            last_q     <= last_d;
            pad_pend_q <= pad_pend_d;
        end
    end

endmodule

// File: tb/tb_keccak_absorb_sipo.sv
// tb/tb_keccak_absorb_sipo.sv - self-checking bench for keccak_absorb_sipo
module tb_keccak_absorb_sipo;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_data;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          blk_valid;
    logic          blk_ready;
    logic [1343:0] blk_data;
    logic          blk_last;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [1343:0] exp_q[$];
    bit            exp_last_q[$];
    logic [1343:0] last_blk = '0;
    logic [1343:0] prev_data = '0;
    logic          prev_last = 1'b0;
    bit            hold_pend = 1'b0;

    keccak_absorb_sipo #(.W(64), .RATE_MAX(1344)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [1343:0] act, input logic [1343:0] exp);
        int idx;
        checks++;
        if (act !== exp) begin
            errors++;
            idx = 0;
            for (int i = 20; i >= 0; i--) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) idx = i;
            end
            $display("FAIL %s word %0d actual=%h required=%h", nm, idx, act[idx*64 +: 64], exp[idx*64 +: 64]);
        end
    endtask

    function automatic logic [63:0] wgen(input int seed, input int i);
        return {32'(seed * 32'h01000193 + i * 32'h00010007 + 32'h5A3C0000), 32'(32'hC0DE0101 + i * 3 + seed * 32'h11)};
    endfunction

    function automatic int rate_bytes(input int m);
        case (m)
            0: return 144;
            1: return 136;
            2: return 104;
            3: return 72;
            5: return 136;
            default: return 168;
        endcase
    endfunction

    // Expected blocks from the message as a byte string: pad10*1 to a rate multiple, then slice
    task automatic model_push(input int m, input int seed, input int n, input int lb);
        int mm, r, l, nblk, nb;
        logic [63:0] w;
        logic [1343:0] v;
        byte unsigned msg[$];
        byte unsigned pd[];
        mm = (m > 5) ? 4 : m;
        r  = rate_bytes(mm);
        for (int i = 0; i < n; i++) begin
            w  = wgen(seed, i);
            nb = 8;
`ifdef KECCAK_SIPO_PAD_EN
            if (i == n - 1) nb = lb;
`endif
            for (int j = 0; j < nb; j++) msg.push_back(w[8*j +: 8]);
        end
        l = msg.size();
`ifdef KECCAK_SIPO_PAD_EN
        nblk = l / r + 1;
`else
        nblk = (l + r - 1) / r;
`endif
        pd = new[nblk * r];
        foreach (pd[k]) pd[k] = 8'h00;
        for (int k = 0; k < l; k++) pd[k] = msg[k];
`ifdef KECCAK_SIPO_PAD_EN
        pd[l] = (mm >= 4) ? 8'h1F : 8'h06;
        pd[nblk*r - 1] = pd[nblk*r - 1] | 8'h80;
`endif
        for (int b = 0; b < nblk; b++) begin
            v = '0;
            for (int k = 0; k < r; k++) v[8*k +: 8] = pd[b*r + k];
            exp_q.push_back(v);
            exp_last_q.push_back(b == nblk - 1);
        end
    endtask

    // Compare process: every accepted block against the model, every stalled cycle for stability
    always @(negedge clk) begin
        logic [1343:0] ed;
        bit el;
        if (rst_n !== 1'b1) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", 64'(blk_valid), 64'd1);
                chk_blk("hold_data", blk_data, prev_data);
                chk("hold_last", 64'(blk_last), 64'(prev_last));
            end
            if (blk_valid === 1'b1) begin
                chk("in_ready_while_full", 64'(in_ready), 64'd0);
                if (blk_ready && !start) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_block actual=block required=none");
                    end else begin
                        ed = exp_q.pop_front();
                        el = exp_last_q.pop_front();
                        chk_blk("blk_data", blk_data, ed);
                        chk("blk_last", 64'(blk_last), 64'(el));
                        last_blk = blk_data;
                    end
                end
            end
            hold_pend = (blk_valid === 1'b1) && !blk_ready && !start;
            prev_data = blk_data;
            prev_last = blk_last;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int m);
        mode  = 3'(m);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] d, input bit last, input int nb);
        int t;
        bit acc;
        t = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = 4'(nb);
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = (in_ready === 1'b1);
            step();
            t++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL word_accept_timeout actual=%0d cycles required=accept", t);
        end
    endtask

    task automatic send_msg(input int m, input int seed, input int n, input int lb, input bit with_last);
        if (with_last) model_push(m, seed, n, lb);
        for (int i = 0; i < n; i++) begin
            send_word(wgen(seed, i), with_last && (i == n - 1), (i == n - 1) ? lb : 8);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 400) begin
            errors++;
            $display("FAIL %s idle_timeout actual=busy required=idle", nm);
        end
        chk({nm, "_blocks_left"}, 64'(exp_q.size()), 64'd0);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        logic [1343:0] exp_v;
        logic [1343:0] tmp;

        rst_n = 1'b0; start = 1'b0; mode = 3'd0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; in_bytes = '0; blk_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_blk_valid", 64'(blk_valid), 64'd0);
        chk("rst_blk_last", 64'(blk_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk_blk("rst_blk_data", blk_data, '0);
        step();
        rst_n = 1'b1;

        // words offered in IDLE are ignored
        in_valid = 1'b1; in_data = 64'hDEAD_BEEF_0000_0001;
        repeat (3) step();
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        step();
        in_valid = 1'b0;

        // SHA3-256, one last word with no valid bytes
        do_start(1);
        send_msg(1, 1, 1, 0, 1'b1);
        wait_idle("t_single");
`ifdef KECCAK_SIPO_PAD_EN
        chk("t_single_dom", 64'(last_blk[7:0]), 64'h06);
        chk("t_single_endbit", 64'(last_blk[1087]), 64'd1);
        tmp = last_blk; tmp[7:0] = 8'h00; tmp[1087] = 1'b0;
        chk_blk("t_single_rest", tmp, '0);
`else
        exp_v = '0; exp_v[63:0] = wgen(1, 0);
        chk_blk("t_single_word", last_blk, exp_v);
`endif

        // SHA3-512, exactly one rate of full words
        do_start(3);
        send_msg(3, 2, 9, 8, 1'b1);
        wait_idle("t_fullrate");
`ifdef KECCAK_SIPO_PAD_EN
        exp_v = '0; exp_v[7:0] = 8'h06; exp_v[575:568] = 8'h80;
        chk_blk("t_fullrate_padblk", last_blk, exp_v);
`else
        chk("t_fullrate_lastword", last_blk[575:512], wgen(2, 8));
`endif

        // SHAKE128, 21 words, consumer stalls
        blk_ready = 1'b0;
        do_start(4);
        send_msg(4, 3, 21, 8, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(blk_valid), 64'd1);
            chk("stall_in_ready", 64'(in_ready), 64'd0);
        end
        step();
        blk_ready = 1'b1;
        wait_idle("t_stall");

        // SHA3-384 aborted after 4 words; start also drops a word offered that cycle
        do_start(2);
        send_msg(2, 4, 4, 8, 1'b0);
        in_valid = 1'b1; in_data = 64'hBAD0_BAD0_BAD0_BAD0; in_last = 1'b1; in_bytes = 4'd8;
        mode = 3'd2; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        send_msg(2, 11, 5, 5, 1'b1);
        wait_idle("t_abort");

        // SHA3-224, last on word 3
        do_start(0);
        send_msg(0, 5, 3, 5, 1'b1);
        wait_idle("t_224");
`ifndef KECCAK_SIPO_PAD_EN
        exp_v = '0; exp_v[191:0] = {wgen(5, 2), wgen(5, 1), wgen(5, 0)};
        chk_blk("t_224_words", last_blk, exp_v);
`endif

        // mode 7 folds onto SHAKE128
        do_start(7);
        send_msg(7, 6, 2, 8, 1'b1);
        wait_idle("t_mode7");

        // mode input changes mid-message; full last word off the block end
        do_start(1);
        mode = 3'd3;
        send_msg(1, 7, 20, 8, 1'b1);
        wait_idle("t_modechg");

        // start while a full block waits is discarded
        blk_ready = 1'b0;
        do_start(3);
        send_msg(3, 8, 9, 8, 1'b0);
        @(negedge clk);
        chk("pend_valid", 64'(blk_valid), 64'd1);
        step();
        do_start(1);
        blk_ready = 1'b1;
        @(negedge clk);
        chk("discard_valid", 64'(blk_valid), 64'd0);
        chk("discard_in_ready", 64'(in_ready), 64'd1);
        step();
        send_msg(1, 9, 2, 3, 1'b1);
        wait_idle("t_discard");

        // reset with start and a word on the same edge
        do_start(2);
        send_msg(2, 10, 2, 8, 1'b0);
        rst_n = 1'b0; start = 1'b1; mode = 3'd1; in_valid = 1'b1; in_data = 64'h1234_5678_9ABC_DEF0;
        step();
        @(negedge clk);
        chk("rstpri_busy", 64'(busy), 64'd0);
        chk("rstpri_in_ready", 64'(in_ready), 64'd0);
        chk("rstpri_blk_valid", 64'(blk_valid), 64'd0);
        chk("rstpri_blk_last", 64'(blk_last), 64'd0);
        chk_blk("rstpri_blk_data", blk_data, '0);
        step();
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 64'(busy), 64'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_absorb_sipo.md
KECCAK_ABSORB_SIPO -- requirements
Module: keccak_absorb_sipo

Interface
REQ-001 SHALL have parameter W, default 64: input word width in bits, legal values 8/16/32/64.
REQ-002 SHALL have parameter RATE_MAX, default 1344: width of the block output in bits (the SHAKE128 rate).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1: begin a new message; clears the buffer and samples mode.
REQ-006 SHALL have port mode, input, 3: 0 SHA3-224 (1152 bits), 1 SHA3-256 (1088), 2 SHA3-384 (832), 3 SHA3-512 (576), 4 SHAKE128 (1344), 5 SHAKE256 (1088); values 6 and 7 are treated as 4.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, W): the word-input handshake.
REQ-008 SHALL have port in_last, input, 1: marks the final word of the message.
REQ-009 SHALL have port in_bytes, input, clog2(W/8)+1: number of valid low-order bytes in the last word, 0..W/8; sampled only when in_last is high.
REQ-010 SHALL have ports blk_valid (output, 1), blk_ready (input, 1) and blk_data (output, RATE_MAX): the block-output handshake.
REQ-011 SHALL have port blk_last, output, 1: high with the final block of a message.
REQ-012 SHALL have port busy, output, 1: high whenever the block is not in IDLE.

Function
REQ-013 SHALL use FSM states IDLE, FILL, PAD and FULL; start moves any state to FILL on the next cycle.
REQ-014 SHALL hold in_ready high only in FILL; a word is accepted when in_valid and in_ready are both high.
REQ-015 SHALL write accepted word k (0-based within the block) to blk_data[k*W +: W], i.e. the first word is least significant, matching Keccak lane order.
REQ-016 SHALL use a word counter that runs 0..RW-1, where RW = rate/W for the latched mode; the counter wraps to 0 after each block is accepted.
REQ-017 SHALL keep blk_data bits at or above the rate at 0 at all times.
REQ-018 SHALL enter FULL with blk_valid high on the cycle after word RW-1 is accepted, or after an in_last word that completes the message.
REQ-019 SHALL, in FULL, hold blk_data, blk_valid and blk_last stable until blk_ready is high; on the accept edge it clears the buffer and moves to FILL if more input is expected, to PAD if padding is pending, or to IDLE after the last block.
REQ-020 SHALL latch mode only on start; mode changes in mid-message are ignored.
REQ-021 SHALL ignore in_valid while in IDLE.
REQ-022 SHALL, when start arrives during FILL, PAD or FULL, discard the partial or pending block without emitting it.
REQ-023 SHALL give start priority over a word accepted on the same cycle; that word is dropped.

Reset
REQ-024 SHALL, when rst_n is low at a clock edge, force state IDLE, counter 0, blk_data 0, and in_ready, blk_valid, blk_last and busy to 0.
REQ-025 SHALL give rst_n priority over start and over both handshakes on the same cycle.

Configuration
REQ-026 SHALL compile the pad10*1 padder in when the macro KECCAK_SIPO_PAD_EN is defined.
REQ-027 SHALL, with the padder in, on the in_last word place a domain byte at byte index in_bytes: 0x06 for SHA3 modes, 0x1F for SHAKE modes.
REQ-028 SHALL, with the padder in, zero all later bytes of the block and OR 0x80 into the final rate byte; if the domain byte and 0x80 fall in the same byte, the result is 0x86 or 0x9F.
REQ-029 SHALL, with the padder in and in_bytes = W/8 on word RW-1, emit that block with blk_last low, then build one pad block in PAD with no input accepted and blk_last high.
REQ-030 SHALL, with the padder in and in_bytes = W/8 on a word other than RW-1, put the domain byte at the start of the next word.
REQ-031 SHALL, with the padder out, ignore in_bytes, zero-fill the remainder of the block after in_last and emit it with blk_last high; PAD is then unreachable.

Structure
REQ-032 SHALL take the mode encoding, the rate table in bits and words, and the domain byte constants from package keccak_pkg.
REQ-033 SHALL place per-byte pad masking in sub-module keccak_pad_byte (combinational, byte index in, mask and value out); it exists only when KECCAK_SIPO_PAD_EN is defined.

Verification
REQ-034 SHALL cover: W=64, padder in, SHA3-256, start, one word in_last=1 in_bytes=0 -> one block with blk_data[7:0]=0x06, bit 1087 set, all other bits 0, blk_last=1.
REQ-035 SHALL cover: W=64, padder in, SHA3-512, 9 full words with in_last on word 9 -> block 1 (blk_last=0) equals the data; block 2 has byte0=0x06, byte71=0x80, blk_last=1.
REQ-036 SHALL cover: SHAKE128, 21 words, blk_ready held low for 5 cycles -> blk_valid and blk_data stable for all 5 cycles, in_ready=0, no word lost.
REQ-037 SHALL cover: start pulsed after 4 accepted words of a SHA3-384 message -> no block emitted; the next message's block has correct contents.
REQ-038 SHALL cover: rst_n low on the same cycle as start with in_valid=1 -> the next cycle shows IDLE and all outputs 0.
REQ-039 SHALL cover: padder out, SHA3-224, in_last on word 3 -> block has words 0-2 as data, remaining bits 0, blk_last=1.
